// File: rtl/cond_seq_pkg.sv
// ============================================================================
//  Module      : cond_seq_pkg
//  Description : Shared constants, state encoding and condition codes for the
//                conditional-execution sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_seq_pkg;

  localparam int COND_W = 4;
  localparam int FLAG_W = 2;
  localparam int CNT_W  = 16;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EVAL = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;

  localparam logic [COND_W-1:0] COND_AL     = 4'd0;
  localparam logic [COND_W-1:0] COND_NV     = 4'd1;
  localparam logic [COND_W-1:0] COND_F1     = 4'd2;
  localparam logic [COND_W-1:0] COND_F2     = 4'd3;
  localparam logic [COND_W-1:0] COND_NF1    = 4'd4;
  localparam logic [COND_W-1:0] COND_NF1B   = 4'd5;
  localparam logic [COND_W-1:0] COND_AND    = 4'd6;
  localparam logic [COND_W-1:0] COND_OR     = 4'd7;
  localparam logic [COND_W-1:0] COND_XOR    = 4'd8;
  localparam logic [COND_W-1:0] COND_XNOR   = 4'd9;
  localparam logic [COND_W-1:0] COND_NAND   = 4'd10;
  localparam logic [COND_W-1:0] COND_NOR    = 4'd11;
  localparam logic [COND_W-1:0] COND_F1ANF2 = 4'd12;
  // ~f1 & f2
  localparam logic [COND_W-1:0] COND_F1NF2  = 4'd13;

endpackage

`default_nettype wire

// File: rtl/cond_eval_unit.sv
// ============================================================================
//  Module      : cond_eval_unit
//  Description : Combinational condition evaluator over the two flag groups.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_eval_unit #(
  parameter int COND_W = cond_seq_pkg::COND_W,
  parameter int FLAG_W = cond_seq_pkg::FLAG_W
) (
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] f1,
  input  logic [FLAG_W-1:0] f2,
  output logic              pass
);
  import cond_seq_pkg::*;

  logic [FLAG_W-1:0] res;
  logic              unused_hi;

  always_comb begin
    res = '0;
    case (cond)
      COND_AL:     res = {FLAG_W{1'b1}};
      COND_NV:     res = '0;
      COND_F1:     res = f1;
      COND_F2:     res = f2;
      COND_NF1:    res = ~f1;
      COND_NF1B:   res = ~f1;
      COND_AND:    res = f1 & f2;
      COND_OR:     res = f1 | f2;
      COND_XOR:    res = f1 ^ f2;
      COND_XNOR:   res = ~(f1 ^ f2);
      COND_NAND:   res = ~(f1 & f2);
      COND_NOR:    res = ~(f1 | f2);
      COND_F1ANF2: res = f1 & ~f2;
      COND_F1NF2:  res = ~f1 & f2;
      default:     res = '0;
    endcase
  end

  // Only bit 0 of the bitwise result decides the condition.
  assign pass      = res[0];
  assign unused_hi = |res[FLAG_W-1:1];

endmodule

`default_nettype wire

// File: rtl/cond_exec_sequencer.sv
// ============================================================================
//  Module      : cond_exec_sequencer
//  Description : Multicycle conditional-execution controller (IDLE/EVAL/EXEC/
//                WB/SKIP). Optional skip counter enabled by COND_SKIP_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_exec_sequencer #(
  parameter int COND_W = cond_seq_pkg::COND_W,
  parameter int FLAG_W = cond_seq_pkg::FLAG_W,
  parameter int CNT_W  = cond_seq_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [COND_W-1:0] cond,
  input  logic [1:0]        flag_wr,
  input  logic              reg_wr_req,
  input  logic              mem_wr_req,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [FLAG_W-1:0] alu_flags1,
  input  logic [FLAG_W-1:0] alu_flags2,
  output logic              reg_we,
  output logic              mem_we,
  output logic              skipped,
  output logic [FLAG_W-1:0] flags1,
  output logic [FLAG_W-1:0] flags2,
  output logic [CNT_W-1:0]  skip_count
);
  import cond_seq_pkg::*;

  logic [2:0]        state_q, state_d;
  logic [COND_W-1:0] cond_q, cond_d;
  logic [1:0]        flag_wr_q, flag_wr_d;
  logic              reg_wr_q, reg_wr_d;
  logic              mem_wr_q, mem_wr_d;
  logic              exec_first_q, exec_first_d;
  logic [FLAG_W-1:0] alu_f1_q, alu_f1_d;
  logic [FLAG_W-1:0] alu_f2_q, alu_f2_d;
  logic [FLAG_W-1:0] flags1_q, flags1_d;
  logic [FLAG_W-1:0] flags2_q, flags2_d;
  logic              cond_pass;

  cond_eval_unit #(
    .COND_W (COND_W),
    .FLAG_W (FLAG_W)
  ) u_cond_eval (
    .cond (cond_q),
    .f1   (flags1_q),
    .f2   (flags2_q),
    .pass (cond_pass)
  );

  always_comb begin
    state_d      = state_q;
    cond_d       = cond_q;
    flag_wr_d    = flag_wr_q;
    reg_wr_d     = reg_wr_q;
    mem_wr_d     = mem_wr_q;
    exec_first_d = 1'b0;
    alu_f1_d     = alu_f1_q;
    alu_f2_d     = alu_f2_q;
    flags1_d     = flags1_q;
    flags2_d     = flags2_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          cond_d    = cond;
          flag_wr_d = flag_wr;
          reg_wr_d  = reg_wr_req;
          mem_wr_d  = mem_wr_req;
          state_d   = ST_EVAL;
        end
      end
      ST_EVAL: begin
        exec_first_d = cond_pass;
        state_d      = cond_pass ? ST_EXEC : ST_SKIP;
      end
      ST_EXEC: begin
        if (alu_done) begin
          alu_f1_d = alu_flags1;
          alu_f2_d = alu_flags2;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        if (flag_wr_q[0]) flags1_d = alu_f1_q;
        if (flag_wr_q[1]) flags2_d = alu_f2_q;
        state_d = ST_IDLE;
      end
      ST_SKIP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cond_q       <= '0;
      flag_wr_q    <= '0;
      reg_wr_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      exec_first_q <= 1'b0;
      alu_f1_q     <= '0;
      alu_f2_q     <= '0;
      flags1_q     <= '0;
      flags2_q     <= '0;
    end else begin
      state_q      <= state_d;
      cond_q       <= cond_d;
      flag_wr_q    <= flag_wr_d;
      reg_wr_q     <= reg_wr_d;
      mem_wr_q     <= mem_wr_d;
      exec_first_q <= exec_first_d;
      alu_f1_q     <= alu_f1_d;
      alu_f2_q     <= alu_f2_d;
      flags1_q     <= flags1_d;
      flags2_q     <= flags2_d;
    end
  end

  // Pure state decodes: an async reset forces IDLE, so no enable can glitch.
  assign instr_ready = (state_q == ST_IDLE);
  assign alu_start   = (state_q == ST_EXEC) && exec_first_q;
  assign reg_we      = (state_q == ST_WB) && reg_wr_q;
  assign mem_we      = (state_q == ST_WB) && mem_wr_q;
  assign skipped     = (state_q == ST_SKIP);
  assign flags1      = flags1_q;
  assign flags2      = flags2_q;

`ifdef COND_SKIP_CNT_EN
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  always_comb begin
    skip_cnt_d = skip_cnt_q;
    if ((state_q == ST_SKIP) && (skip_cnt_q != {CNT_W{1'b1}})) begin
      skip_cnt_d = skip_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_cnt_q <= '0;
    else        skip_cnt_q <= skip_cnt_d;
  end

  assign skip_count = skip_cnt_q;
`else
  assign skip_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_exec_sequencer.sv
// ============================================================================
//  Module      : tb_cond_exec_sequencer
//  Description : Scoreboard bench for cond_exec_sequencer; directed vectors
//                with hand-computed outcomes (honours COND_SKIP_CNT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_exec_sequencer;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                instr_valid = 1'b0;
  logic                instr_ready;
  logic [3:0]          cond = '0;
  logic [1:0]          flag_wr = '0;
  logic                reg_wr_req = 1'b0;
  logic                mem_wr_req = 1'b0;
  logic                alu_start;
  logic                alu_done = 1'b0;
  logic [1:0]          alu_flags1 = '0;
  logic [1:0]          alu_flags2 = '0;
  logic                reg_we;
  logic                mem_we;
  logic                skipped;
  logic [1:0]          flags1;
  logic [1:0]          flags2;
  logic [TB_CNT_W-1:0] skip_count;

  cond_exec_sequencer #(
    .COND_W (4),
    .FLAG_W (2),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .cond        (cond),
    .flag_wr     (flag_wr),
    .reg_wr_req  (reg_wr_req),
    .mem_wr_req  (mem_wr_req),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_flags1  (alu_flags1),
    .alu_flags2  (alu_flags2),
    .reg_we      (reg_we),
    .mem_we      (mem_we),
    .skipped     (skipped),
    .flags1      (flags1),
    .flags2      (flags2),
    .skip_count  (skip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         busy;
    int         starts;
    int         regs;
    int         mems;
    int         skips;
    logic [1:0] f1;
    logic [1:0] f2;
    int         cnt;
  } exp_t;

  typedef struct {
    logic [3:0] c;
    logic [1:0] fw;
    logic       rg;
    logic       mm;
    logic [1:0] a1;
    logic [1:0] a2;
    int         d;
    logic       ex;
    logic [1:0] e1;
    logic [1:0] e2;
  } vec_t;

  exp_t sb_q[$];
  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sc_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic [3:0] c, input logic [1:0] fw, input logic rg,
                       input logic mm, input logic [1:0] a1, input logic [1:0] a2,
                       input int d, input logic ex, input logic [1:0] e1,
                       input logic [1:0] e2);
    vec_t v;
    v.c = c; v.fw = fw; v.rg = rg; v.mm = mm; v.a1 = a1; v.a2 = a2;
    v.d = d; v.ex = ex; v.e1 = e1; v.e2 = e2;
    vq.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!instr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(name, {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic run_instr(input vec_t v);
    exp_t e;
    int   t;
    wait_ready("ready_before_issue");
    e.busy   = v.ex ? 3 + v.d : 2;
    e.starts = v.ex ? 1 : 0;
    e.regs   = (v.ex && v.rg) ? 1 : 0;
    e.mems   = (v.ex && v.mm) ? 1 : 0;
    e.skips  = v.ex ? 0 : 1;
    e.f1     = v.e1;
    e.f2     = v.e2;
    if (!v.ex && sc_model < (1 << TB_CNT_W) - 1) sc_model++;
`ifdef COND_SKIP_CNT_EN
    e.cnt = sc_model;
`else
    e.cnt = 0;
`endif
    sb_q.push_back(e);
    instr_valid = 1'b1;
    cond        = v.c;
    flag_wr     = v.fw;
    reg_wr_req  = v.rg;
    mem_wr_req  = v.mm;
    alu_flags1  = v.a1;
    alu_flags2  = v.a2;
    alu_done    = (v.d == 0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    cond        = ~v.c;
    flag_wr     = ~v.fw;
    reg_wr_req  = ~v.rg;
    mem_wr_req  = ~v.mm;
    if (v.ex && v.d > 0) begin
      t = 0;
      @(negedge clk);
      while (!alu_start && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("alu_start_seen", {31'd0, alu_start}, 32'd1);
      repeat (v.d) @(negedge clk);
      alu_done = 1'b1;
    end
    @(negedge clk);
    wait_ready("ready_after_instr");
    alu_done = 1'b0;
  endtask

  // Monitor: accumulates activity while busy, compares when ready returns.
  initial begin
    int busy = 0, starts = 0, regs = 0, mems = 0, skips = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; starts = 0; regs = 0; mems = 0; skips = 0;
      end else if (!instr_ready) begin
        busy++;
        starts += int'(alu_start);
        regs   += int'(reg_we);
        mems   += int'(mem_we);
        skips  += int'(skipped);
      end else if (busy > 0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("latency",    busy,   e.busy);
          chk("alu_starts", starts, e.starts);
          chk("reg_we",     regs,   e.regs);
          chk("mem_we",     mems,   e.mems);
          chk("skipped",    skips,  e.skips);
          chk("flags1",     {30'd0, flags1}, {30'd0, e.f1});
          chk("flags2",     {30'd0, flags2}, {30'd0, e.f2});
          chk("skip_count", {28'd0, skip_count}, e.cnt);
        end
        busy = 0; starts = 0; regs = 0; mems = 0; skips = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"},     {31'd0, instr_ready}, 32'd1);
    chk({tag, "_alu_start"}, {31'd0, alu_start},   32'd0);
    chk({tag, "_reg_we"},    {31'd0, reg_we},      32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we},      32'd0);
    chk({tag, "_skipped"},   {31'd0, skipped},     32'd0);
    chk({tag, "_flags1"},    {30'd0, flags1},      32'd0);
    chk({tag, "_flags2"},    {30'd0, flags2},      32'd0);
    chk({tag, "_skip_cnt"},  {28'd0, skip_count},  32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    //     cond   fw     rg    mm    a1     a2     d  ex    e1     e2
    add_v(4'd0,  2'b00, 1'b1, 1'b0, 2'b11, 2'b11, 0, 1'b1, 2'b00, 2'b00);
    add_v(4'd1,  2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0, 2'b00, 2'b00);
    add_v(4'd0,  2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 0, 1'b1, 2'b01, 2'b00);
    add_v(4'd2,  2'b10, 1'b1, 1'b1, 2'b00, 2'b11, 0, 1'b1, 2'b01, 2'b11);
    add_v(4'd4,  2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b0, 2'b01, 2'b11);
    add_v(4'd6,  2'b11, 1'b0, 1'b1, 2'b10, 2'b01, 5, 1'b1, 2'b10, 2'b01);
    add_v(4'd8,  2'b00, 1'b1, 1'b0, 2'b11, 2'b11, 0, 1'b1, 2'b10, 2'b01);
    add_v(4'd12, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0, 2'b10, 2'b01);
    add_v(4'd13, 2'b01, 1'b1, 1'b0, 2'b11, 2'b00, 0, 1'b1, 2'b11, 2'b01);
    add_v(4'd14, 2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b0, 2'b11, 2'b01);
    add_v(4'd15, 2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b0, 2'b11, 2'b01);
    add_v(4'd11, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0, 2'b11, 2'b01);
    add_v(4'd9,  2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2, 1'b1, 2'b00, 2'b00);
    add_v(4'd10, 2'b00, 1'b0, 1'b0, 2'b11, 2'b11, 0, 1'b1, 2'b00, 2'b00);
    add_v(4'd3,  2'b11, 1'b1, 1'b1, 2'b11, 2'b11, 0, 1'b0, 2'b00, 2'b00);
    add_v(4'd5,  2'b11, 1'b1, 1'b0, 2'b01, 2'b10, 0, 1'b1, 2'b01, 2'b10);
    add_v(4'd7,  2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1, 1'b1, 2'b01, 2'b10);
    foreach (vq[i]) run_instr(vq[i]);

    // Reset asserted while the ALU is still busy.
    wait_ready("ready_before_rst_test");
    instr_valid = 1'b1; cond = 4'd0; flag_wr = 2'b11;
    reg_wr_req = 1'b1; mem_wr_req = 1'b1;
    alu_flags1 = 2'b11; alu_flags2 = 2'b11; alu_done = 1'b0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!alu_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rst_test_alu_start", {31'd0, alu_start}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_exec_rst");
    sc_model = 0;
    alu_done = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("stray_done");
    end
    alu_done = 1'b0;

    // Never-true conditions, enough of them to saturate the counter.
    for (int k = 0; k < (1 << TB_CNT_W) + 3; k++) begin
      vec_t v;
      v.c = (k % 2 == 0) ? 4'd15 : 4'd14;
      v.fw = 2'b11; v.rg = 1'b1; v.mm = 1'b1; v.a1 = 2'b11; v.a2 = 2'b11;
      v.d = 0; v.ex = 1'b0; v.e1 = 2'b00; v.e2 = 2'b00;
      run_instr(v);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
